// File: rtl/fx3_multi_thread_sm.sv
// Round-robin FX3 slave-FIFO write sequencer: picks a ready GPIF thread, drives its
// address, waits for the watermark, then strobes fx3_nWrite/fifo_read for one burst.
module fx3_multi_thread_sm #(
    parameter int NUM_THREADS       = 4,
    parameter int THREAD_ADDR_WIDTH = 2,
    parameter int BURST_WORDS       = 0,
    parameter int ADDR_SETUP        = 1,
    parameter int POST_DELAY        = 1,
    parameter int WM_TIMEOUT        = 1024,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                         fx3_clock,
    input  logic                         fx3_reset,
    input  logic                         fx3_nReady,
    input  logic [NUM_THREADS-1:0]       fx3_thReady,
    input  logic [NUM_THREADS-1:0]       fx3_thWatermark,
    input  logic                         fifo_dataReady,
    output logic                         fx3_nWrite,
    output logic [THREAD_ADDR_WIDTH-1:0] fx3_threadAddr,
    output logic                         fifo_read,
    output logic [COUNT_WIDTH-1:0]       burst_count,
    output logic                         timeout_error
);

    localparam int PHASE_MAX = (ADDR_SETUP > POST_DELAY)
                             ? ((ADDR_SETUP > WM_TIMEOUT) ? ADDR_SETUP : WM_TIMEOUT)
                             : ((POST_DELAY > WM_TIMEOUT) ? POST_DELAY : WM_TIMEOUT);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int WORD_W    = (BURST_WORDS == 0) ? 1 : $clog2(BURST_WORDS + 1);

    localparam logic [PHASE_W-1:0]           ADDR_LAST   = PHASE_W'(ADDR_SETUP - 1);
    localparam logic [PHASE_W-1:0]           DELAY_LAST  = PHASE_W'(POST_DELAY - 1);
    localparam logic [PHASE_W-1:0]           WM_LAST     = PHASE_W'(WM_TIMEOUT - 1);
    localparam logic [PHASE_W-1:0]           PHASE_ONE   = PHASE_W'(1);
    localparam logic [WORD_W-1:0]            WORD_LAST   = WORD_W'(BURST_WORDS - 1);
    localparam logic [WORD_W-1:0]            WORD_MAX    = {WORD_W{1'b1}};
    localparam logic [WORD_W-1:0]            WORD_ONE    = WORD_W'(1);
    localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_THREAD = THREAD_ADDR_WIDTH'(NUM_THREADS - 1);
    localparam logic [THREAD_ADDR_WIDTH-1:0] ADDR_ONE    = THREAD_ADDR_WIDTH'(1);
    localparam logic [THREAD_ADDR_WIDTH:0]   NT_EXT      = (THREAD_ADDR_WIDTH + 1)'(NUM_THREADS);
    localparam logic [COUNT_WIDTH-1:0]       COUNT_ONE   = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WAIT_WM = 3'd2,
        SEND    = 3'd3,
        DELAY   = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic                         nReady_q;
    logic [NUM_THREADS-1:0]       thReady_q;
    logic [NUM_THREADS-1:0]       thWatermark_q;

    logic [THREAD_ADDR_WIDTH-1:0] sel_reg, sel_next;
    logic [THREAD_ADDR_WIDTH-1:0] threadAddr_reg, threadAddr_next;
    logic [THREAD_ADDR_WIDTH-1:0] rrPtr_reg, rrPtr_next;
    logic [PHASE_W-1:0]           phaseCnt_reg, phaseCnt_next;
    logic [WORD_W-1:0]            wordCnt_reg, wordCnt_next;
    logic [COUNT_WIDTH-1:0]       burstCount_reg, burstCount_next;
    logic                         timeoutError_reg, timeoutError_next;
    logic                         nWrite_reg, nWrite_next;
    logic                         fifoRead_reg, fifoRead_next;

    logic                         idleGo;
    logic                         wmSel;
    logic                         addrDone;
    logic                         delayDone;
    logic                         wmTimeout;
    logic                         burstFull;
    logic                         sendStop;
    logic [THREAD_ADDR_WIDTH-1:0] pickIdx;

    always_ff @(posedge fx3_clock) begin
        if (fx3_reset) begin
            nReady_q      <= 1'b1;
            thReady_q     <= '0;
            thWatermark_q <= '0;
        end else begin
            nReady_q      <= fx3_nReady;
            thReady_q     <= fx3_thReady;
            thWatermark_q <= fx3_thWatermark;
        end
    end

    // Rotate the ready vector so that slot 0 is the thread at rrPtr.
    logic [NUM_THREADS-1:0]       rotReady;
    logic [THREAD_ADDR_WIDTH-1:0] rotIdx [NUM_THREADS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_THREADS; gi++) begin : g_rot
            logic [THREAD_ADDR_WIDTH:0] rotSum;
            assign rotSum      = {1'b0, rrPtr_reg} + (THREAD_ADDR_WIDTH + 1)'(gi);
            assign rotIdx[gi]  = (rotSum >= NT_EXT) ? THREAD_ADDR_WIDTH'(rotSum - NT_EXT)
                                                    : rotSum[THREAD_ADDR_WIDTH-1:0];
            assign rotReady[gi] = thReady_q[rotIdx[gi]];
        end
    endgenerate

    always_comb begin
        pickIdx = '0;
        for (int k = NUM_THREADS - 1; k >= 0; k--) begin
            if (rotReady[k]) begin
                pickIdx = rotIdx[k];
            end
        end
    end

    assign idleGo    = !nReady_q && fifo_dataReady && (|thReady_q);
    assign wmSel     = thWatermark_q[sel_reg];
    assign addrDone  = (phaseCnt_reg == ADDR_LAST);
    assign delayDone = (phaseCnt_reg == DELAY_LAST);
    assign wmTimeout = (WM_TIMEOUT != 0) && (phaseCnt_reg == WM_LAST);
    assign burstFull = (BURST_WORDS != 0) && (wordCnt_reg == WORD_LAST);
    assign sendStop  = !wmSel || nReady_q || !fifo_dataReady || burstFull;

    always_ff @(posedge fx3_clock) begin
        if (fx3_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (idleGo)                state_next = ADDR;
            ADDR:    if (addrDone)              state_next = WAIT_WM;
            WAIT_WM: begin
                // A watermark arriving on the timeout cycle still wins.
                if (wmSel)                      state_next = SEND;
                else if (wmTimeout)             state_next = DELAY;
            end
            SEND:    if (sendStop)              state_next = DELAY;
            DELAY:   if (delayDone)             state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_next          = sel_reg;
        threadAddr_next   = threadAddr_reg;
        rrPtr_next        = rrPtr_reg;
        phaseCnt_next     = phaseCnt_reg;
        wordCnt_next      = wordCnt_reg;
        burstCount_next   = burstCount_reg;
        timeoutError_next = timeoutError_reg;
        nWrite_next       = (state_reg != SEND);
        fifoRead_next     = (state_reg == SEND);
        case (state_reg)
            IDLE: begin
                phaseCnt_next = '0;
                if (idleGo) begin
                    sel_next        = pickIdx;
                    threadAddr_next = pickIdx;
                end
            end
            ADDR: begin
                phaseCnt_next = addrDone ? '0 : phaseCnt_reg + PHASE_ONE;
            end
            WAIT_WM: begin
                if (wmSel) begin
                    phaseCnt_next = '0;
                end else if (wmTimeout) begin
                    phaseCnt_next     = '0;
                    timeoutError_next = 1'b1;
                end else begin
                    phaseCnt_next = phaseCnt_reg + PHASE_ONE;
                end
            end
            SEND: begin
                // Saturation only matters in unlimited mode, where just non-zero is needed.
                if (wordCnt_reg != WORD_MAX) begin
                    wordCnt_next = wordCnt_reg + WORD_ONE;
                end
                phaseCnt_next = '0;
            end
            DELAY: begin
                if (delayDone) begin
                    phaseCnt_next = '0;
                    wordCnt_next  = '0;
                    rrPtr_next    = (sel_reg == LAST_THREAD) ? '0 : sel_reg + ADDR_ONE;
                    if (wordCnt_reg != '0) begin
                        burstCount_next = burstCount_reg + COUNT_ONE;
                    end
                end else begin
                    phaseCnt_next = phaseCnt_reg + PHASE_ONE;
                end
            end
            default: begin
                phaseCnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge fx3_clock) begin
        if (fx3_reset) begin
            sel_reg          <= '0;
            threadAddr_reg   <= '0;
            rrPtr_reg        <= '0;
            phaseCnt_reg     <= '0;
            wordCnt_reg      <= '0;
            burstCount_reg   <= '0;
            timeoutError_reg <= 1'b0;
            nWrite_reg       <= 1'b1;
            fifoRead_reg     <= 1'b0;
        end else begin
            sel_reg          <= sel_next;
            threadAddr_reg   <= threadAddr_next;
            rrPtr_reg        <= rrPtr_next;
            phaseCnt_reg     <= phaseCnt_next;
            wordCnt_reg      <= wordCnt_next;
            burstCount_reg   <= burstCount_next;
            timeoutError_reg <= timeoutError_next;
            nWrite_reg       <= nWrite_next;
            fifoRead_reg     <= fifoRead_next;
        end
    end

    assign fx3_nWrite     = nWrite_reg;
    assign fifo_read      = fifoRead_reg;
    assign fx3_threadAddr = threadAddr_reg;
    assign burst_count    = burstCount_reg;
    assign timeout_error  = timeoutError_reg;

endmodule

// File: tb/tb_fx3_multi_thread_sm.sv
// Scoreboard bench for fx3_multi_thread_sm: expected bursts (thread, length) are queued
// as stimulus is applied and compared when the strobe run on fx3_nWrite completes.
module tb_fx3_multi_thread_sm;

    localparam int NT  = 4;
    localparam int TAW = 2;
    localparam int BW  = 16;
    localparam int AS  = 1;
    localparam int PD  = 1;
    localparam int WT  = 10;
    localparam int CW  = 16;
    // nWrite-high cycles between back-to-back bursts: DELAY, IDLE, ADDR, WAIT_WM.
    localparam int GAP = PD + 1 + AS + 1;

    logic            fx3_clock = 1'b0;
    logic            fx3_reset = 1'b0;
    logic            fx3_nReady = 1'b1;
    logic [NT-1:0]   fx3_thReady = '0;
    logic [NT-1:0]   fx3_thWatermark = '0;
    logic            fifo_dataReady = 1'b0;
    logic            fx3_nWrite;
    logic [TAW-1:0]  fx3_threadAddr;
    logic            fifo_read;
    logic [CW-1:0]   burst_count;
    logic            timeout_error;

    fx3_multi_thread_sm #(
        .NUM_THREADS      (NT),
        .THREAD_ADDR_WIDTH(TAW),
        .BURST_WORDS      (BW),
        .ADDR_SETUP       (AS),
        .POST_DELAY       (PD),
        .WM_TIMEOUT       (WT),
        .COUNT_WIDTH      (CW)
    ) dut (
        .fx3_clock      (fx3_clock),
        .fx3_reset      (fx3_reset),
        .fx3_nReady     (fx3_nReady),
        .fx3_thReady    (fx3_thReady),
        .fx3_thWatermark(fx3_thWatermark),
        .fifo_dataReady (fifo_dataReady),
        .fx3_nWrite     (fx3_nWrite),
        .fx3_threadAddr (fx3_threadAddr),
        .fifo_read      (fifo_read),
        .burst_count    (burst_count),
        .timeout_error  (timeout_error)
    );

    always #5 fx3_clock = ~fx3_clock;

    typedef struct {
        int addr;
        int len;
    } burst_t;

    burst_t expQ[$];
    burst_t expB;
    int     checkCount = 0;
    int     errorCount = 0;
    bit     monEn   = 1'b0;
    bit     gapEn   = 1'b0;
    bit     haveGap = 1'b0;
    bit     inBurst = 1'b0;
    int     runLen  = 0;
    int     runAddr = 0;
    int     gapCnt  = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs != exp) begin
            errorCount++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Burst monitor: one scoreboard pop per completed nWrite-low run.
    always @(negedge fx3_clock) begin
        if (monEn) begin
            if (fx3_reset) haveGap = 1'b0;
            if (fx3_nWrite == 1'b0) begin
                if (!inBurst) begin
                    inBurst = 1'b1;
                    runLen  = 0;
                    runAddr = int'(fx3_threadAddr);
                    check_value("rd_start", int'(fifo_read), 1);
                    if (gapEn && haveGap) check_value("gap", gapCnt, GAP);
                end
                runLen++;
            end else if (inBurst) begin
                inBurst = 1'b0;
                gapCnt  = 1;
                haveGap = 1'b1;
                $display("burst addr=%0d len=%0d count=%0d", runAddr, runLen, int'(burst_count));
                check_value("rd_end", int'(fifo_read), 0);
                check_value("burst_expected", int'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    expB = expQ.pop_front();
                    check_value("burst_addr", runAddr, expB.addr);
                    check_value("burst_len", runLen, expB.len);
                end
            end else begin
                gapCnt++;
            end
        end
    end

    task automatic set_idle();
        fx3_nReady      = 1'b1;
        fx3_thReady     = '0;
        fx3_thWatermark = '0;
        fifo_dataReady  = 1'b0;
    endtask

    task automatic start_thread(input logic [NT-1:0] mask);
        fx3_nReady      = 1'b0;
        fx3_thReady     = mask;
        fx3_thWatermark = mask;
        fifo_dataReady  = 1'b1;
    endtask

    task automatic push_burst(input int addr, input int len);
        burst_t b;
        b.addr = addr;
        b.len  = len;
        expQ.push_back(b);
    endtask

    task automatic do_reset();
        @(negedge fx3_clock);
        fx3_reset = 1'b1;
        gapEn     = 1'b0;
        set_idle();
        repeat (3) @(negedge fx3_clock);
        fx3_reset = 1'b0;
    endtask

    task automatic wait_bc(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(burst_count) != target && n < budget) begin
            @(negedge fx3_clock);
            n++;
        end
        check_value(tag, int'(burst_count), target);
    endtask

    // kind 0: watermark drop, 1: nReady rise, 2: dataReady drop, after trig low cycles.
    task automatic stop_burst(input int th, input int kind, input int trig,
                              input int expLen, input int target);
        int n;
        int cnt;
        push_burst(th, expLen);
        start_thread(NT'(1 << th));
        n   = 0;
        cnt = 0;
        while (cnt < trig && n < 200) begin
            @(negedge fx3_clock);
            n++;
            if (fx3_nWrite === 1'b0) cnt++;
        end
        check_value("stop_trigger", cnt, trig);
        case (kind)
            0:       fx3_thWatermark = '0;
            1:       fx3_nReady      = 1'b1;
            default: fifo_dataReady  = 1'b0;
        endcase
        wait_bc(target, 100, "burst_count");
        set_idle();
        repeat (2) @(negedge fx3_clock);
    endtask

    initial begin
        int  n;
        int  cnt;
        bit  toSeen;

        // Reset and idle
        do_reset();
        monEn = 1'b1;
        check_value("rst_nwrite", int'(fx3_nWrite), 1);
        check_value("rst_read", int'(fifo_read), 0);
        check_value("rst_addr", int'(fx3_threadAddr), 0);
        check_value("rst_count", int'(burst_count), 0);
        check_value("rst_timeout", int'(timeout_error), 0);
        repeat (20) @(negedge fx3_clock);
        check_value("idle_nwrite", int'(fx3_nWrite), 1);
        check_value("idle_read", int'(fifo_read), 0);
        check_value("idle_addr", int'(fx3_threadAddr), 0);
        check_value("idle_count", int'(burst_count), 0);

        // Each stop source; registered sources add one cycle of latency over dataReady.
        stop_burst(0, 0, 6, 8, 1);
        stop_burst(1, 1, 3, 5, 2);
        stop_burst(3, 2, 4, 5, 3);

        // Round robin between threads 0 and 2 with burst limit.
        do_reset();
        check_value("rst_count_clr", int'(burst_count), 0);
        gapEn = 1'b1;
        push_burst(0, BW);
        push_burst(2, BW);
        push_burst(0, BW);
        push_burst(2, BW);
        fx3_nReady      = 1'b0;
        fx3_thReady     = 4'b0101;
        fx3_thWatermark = 4'b1111;
        fifo_dataReady  = 1'b1;
        wait_bc(4, 400, "rr_count");
        set_idle();
        gapEn = 1'b0;
        repeat (5) @(negedge fx3_clock);

        // Watermark timeout on thread 1
        do_reset();
        fx3_nReady      = 1'b0;
        fx3_thReady     = 4'b0010;
        fx3_thWatermark = 4'b0000;
        fifo_dataReady  = 1'b1;
        n      = 0;
        cnt    = 0;
        toSeen = 1'b0;
        while (!toSeen && n < 100) begin
            @(negedge fx3_clock);
            n++;
            if (timeout_error === 1'b1) toSeen = 1'b1;
            else if (fx3_threadAddr == 2'd1) cnt++;
        end
        set_idle();
        check_value("timeout_flag", int'(timeout_error), 1);
        check_value("timeout_cycles", cnt, AS + WT);
        repeat (3) @(negedge fx3_clock);
        check_value("timeout_count", int'(burst_count), 0);
        // rr_ptr moved past thread 1, so thread 3 beats thread 0.
        push_burst(3, BW);
        fx3_nReady      = 1'b0;
        fx3_thReady     = 4'b1001;
        fx3_thWatermark = 4'b1001;
        fifo_dataReady  = 1'b1;
        wait_bc(1, 200, "after_timeout_count");
        set_idle();
        repeat (3) @(negedge fx3_clock);
        check_value("timeout_sticky", int'(timeout_error), 1);

        // Reset during the 4th SEND cycle
        do_reset();
        check_value("timeout_clr", int'(timeout_error), 0);
        push_burst(2, 3);
        start_thread(4'b0100);
        n = 0;
        while (fx3_nWrite !== 1'b0 && n < 50) begin
            @(negedge fx3_clock);
            n++;
        end
        check_value("send_seen", int'(fx3_nWrite), 0);
        repeat (2) @(negedge fx3_clock);
        fx3_reset = 1'b1;
        set_idle();
        @(negedge fx3_clock);
        check_value("midrst_nwrite", int'(fx3_nWrite), 1);
        check_value("midrst_read", int'(fifo_read), 0);
        fx3_reset = 1'b0;
        repeat (6) @(negedge fx3_clock);
        check_value("midrst_count", int'(burst_count), 0);
        check_value("midrst_idle", int'(fx3_nWrite), 1);

        check_value("queue_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fx3_multi_thread_sm.md
Name: fx3_multi_thread_sm

Overview:
Parametrised successor to the single-thread FX3 write-strobe sequencer: arbitrates round-robin across up to NUM_THREADS FX3 GPIF sockets and drives the thread address and active-low write strobe.
Adds per-burst word limit, address setup and post-burst delays, watermark timeout detection and a burst counter.
Sits between the sample FIFO (read side) and the FX3 slave-FIFO interface, all in the fx3_clock domain.

Parameters:
NUM_THREADS, 4, number of FX3 threads arbitrated (1..2^THREAD_ADDR_WIDTH)
THREAD_ADDR_WIDTH, 2, width of fx3_threadAddr
BURST_WORDS, 0, max SEND cycles per burst; 0 = unlimited (watermark-terminated)
ADDR_SETUP, 1, cycles in ADDR state after address change (>=1)
POST_DELAY, 1, cycles in DELAY state (>=1)
WM_TIMEOUT, 1024, WAIT_WM cycles before timeout; 0 disables timeout
COUNT_WIDTH, 16, width of burst_count

Ports:
fx3_clock  in  1  single clock; all logic on rising edge
fx3_reset  in  1  synchronous, active-high reset
fx3_nReady  in  1  FX3 not-ready (0 = ready)
fx3_thReady  in  NUM_THREADS  per-thread DMA-ready flags
fx3_thWatermark  in  NUM_THREADS  per-thread watermark flags (1 = room remains)
fifo_dataReady  in  1  sample FIFO holds a burst's worth of data
fx3_nWrite  out  1  active-low write strobe to FX3
fx3_threadAddr  out  THREAD_ADDR_WIDTH  selected thread address
fifo_read  out  1  FIFO read enable, same cycles as fx3_nWrite low
burst_count  out  COUNT_WIDTH  completed bursts, wraps modulo 2^COUNT_WIDTH
timeout_error  out  1  sticky watermark-timeout flag

Behaviour:
- Reset (fx3_reset=1 at edge): state=IDLE, fx3_nWrite=1, fifo_read=0, fx3_threadAddr=0, sel=0, rr_ptr=0, burst_count=0, timeout_error=0, all counters 0.
- Input registering: fx3_nReady, fx3_thReady, fx3_thWatermark pass through one register stage (_q) before use.
  - Reset values: nReady_q=1, thReady_q=0, thWatermark_q=0.
  - fifo_dataReady is used unregistered.
- fx3_nWrite is registered: fx3_nWrite <= !(state==SEND); lags the state by one cycle. fifo_read <= (state==SEND), same register timing.
- IDLE:
  - Qualifier: nReady_q==0 and fifo_dataReady==1 and some thReady_q[i]==1 with i<NUM_THREADS.
  - If qualified, pick the first ready i scanning circularly from rr_ptr; sel<=i, fx3_threadAddr<=i, go to ADDR.
  - Otherwise stay in IDLE.
- ADDR: remain exactly ADDR_SETUP cycles, then go to WAIT_WM.
- WAIT_WM:
  - thWatermark_q[sel]==1: go to SEND.
  - Else, if WM_TIMEOUT!=0 and ADDR_SETUP+wait cycles... specifically, after WM_TIMEOUT consecutive cycles in WAIT_WM: timeout_error<=1, go to DELAY with word count 0.
- SEND: word counter increments each SEND cycle. Go to DELAY at the first edge where any of the following holds (evaluated in order, all equivalent outcome):
  - thWatermark_q[sel]==0;
  - nReady_q==1;
  - fifo_dataReady==0;
  - BURST_WORDS!=0 and word count reaches BURST_WORDS (exactly BURST_WORDS SEND cycles).
- DELAY: remain exactly POST_DELAY cycles, then go to IDLE.
  - On exit, rr_ptr <= (sel+1) mod NUM_THREADS.
  - burst_count increments only if the word count was >0.
  - Word counter clears.
- Simultaneous events:
  - Watermark drop and BURST_WORDS limit on the same edge: a single exit to DELAY, counted once.
  - Timeout and watermark rising on the same cycle: watermark wins (go to SEND, no error).
- NUM_THREADS=1: rr_ptr stays 0; fx3_threadAddr stays 0.
- Reset asserted mid-SEND: fx3_nWrite=1 and fifo_read=0 on the following edge, state IDLE, no burst counted.
- timeout_error clears only on reset.

Test Plan:
- Reset then idle: all inputs idle, 20 cycles -> fx3_nWrite=1, fifo_read=0, fx3_threadAddr=0, burst_count=0.
- Single burst, NUM_THREADS=1, BURST_WORDS=0: thReady=1, nReady=0, dataReady=1; watermark high, drops after 8 cycles -> fx3_nWrite low for exactly 8 cycles, burst_count=1.
- Round-robin, NUM_THREADS=4: threads 0 and 2 permanently ready with watermark -> fx3_threadAddr sequence 0,2,0,2; burst_count increments per burst.
- BURST_WORDS=16, watermark held high -> nWrite low exactly 16 cycles, then POST_DELAY=1 gap before next ADDR.
- WM_TIMEOUT=10, watermark never rises -> timeout_error=1 after 10 WAIT_WM cycles, nWrite never low, burst_count unchanged, rr_ptr advances.
- Reset pulse on 4th SEND cycle -> fx3_nWrite=1 on the next edge, state IDLE, burst_count=0.
